// File: rtl/karatsuba_mult_pipe.sv
// Three-stage pipelined Karatsuba multiplier with valid/ready handshakes,
// per-transaction signed/unsigned mode and a pass-through tag.
module karatsuba_mult_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int H  = WIDTH / 2;
  localparam int DW = 2 * WIDTH;

  // The whole pipe moves in lockstep, so one stall signal freezes every stage.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Stage 1 inputs: sign-magnitude conversion.
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             neg_in;

  always_comb begin
    a_mag  = in_a;
    b_mag  = in_b;
    neg_in = 1'b0;
    if (in_signed) begin
      // The most negative value negates to itself, which is its correct magnitude.
      if (in_a[WIDTH-1]) a_mag = -in_a;
      if (in_b[WIDTH-1]) b_mag = -in_b;
      neg_in = in_a[WIDTH-1] ^ in_b[WIDTH-1];
    end
  end

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_neg;
  logic [TAG_W-1:0] s1_tag;

  // Stage 2: three half-width products.
  logic [H:0]     sum_a;
  logic [H:0]     sum_b;
  logic [2*H-1:0] p1_c;
  logic [2*H-1:0] p0_c;
  logic [2*H+1:0] s_c;

  always_comb begin
    sum_a = {1'b0, s1_a[WIDTH-1:H]} + {1'b0, s1_a[H-1:0]};
    sum_b = {1'b0, s1_b[WIDTH-1:H]} + {1'b0, s1_b[H-1:0]};
    p1_c  = {{H{1'b0}}, s1_a[WIDTH-1:H]} * {{H{1'b0}}, s1_b[WIDTH-1:H]};
    p0_c  = {{H{1'b0}}, s1_a[H-1:0]} * {{H{1'b0}}, s1_b[H-1:0]};
    s_c   = {{(H+1){1'b0}}, sum_a} * {{(H+1){1'b0}}, sum_b};
  end

  logic             s2_valid;
  logic [2*H-1:0]   s2_p1;
  logic [2*H-1:0]   s2_p0;
  logic [2*H+1:0]   s2_s;
  logic             s2_neg;
  logic [TAG_W-1:0] s2_tag;

  // Stage 3: middle term, shifted recombination and sign restore.
  logic [2*H+1:0] mid;
  logic [DW-1:0]  mag_r;
  logic [DW-1:0]  res_c;

  always_comb begin
    mid   = s2_s - {2'b00, s2_p1} - {2'b00, s2_p0};
    mag_r = {s2_p1, {(2*H){1'b0}}}
          + ({{(DW-2*H-2){1'b0}}, mid} << H)
          + {{(2*H){1'b0}}, s2_p0};
    res_c = s2_neg ? -mag_r : mag_r;
  end

  // Control and output registers carry the reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_result <= res_c;
        out_tag    <= s2_tag;
      end
    end
  end

  // NOTE: datapath registers are deliberately left without reset; their
  // contents are ignored until the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (advance) begin
      s1_a   <= a_mag;
      s1_b   <= b_mag;
      s1_neg <= neg_in;
      s1_tag <= in_tag;
      s2_p1  <= p1_c;
      s2_p0  <= p0_c;
      s2_s   <= s_c;
      s2_neg <= s1_neg;
      s2_tag <= s1_tag;
    end
  end

endmodule
